// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction into an ALU op code and two operands,
// then holds the result in a valid/ready pipeline register for the execute stage.
module alu_issue_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;
    localparam logic [3:0] OpXor  = 4'b0101;
    localparam logic [3:0] OpSlt  = 4'b1100;
    localparam logic [3:0] OpSltu = 4'b1101;
    localparam logic [3:0] OpSll  = 4'b1010;
    localparam logic [3:0] OpNop  = 4'b1111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_u;
    logic [3:0]  func_op;
    logic        is_shift;

    logic [3:0]  dec_op;
    logic [31:0] dec_in1, dec_in2;
    logic        dec_illegal;

    logic             valid_q;
    logic [3:0]       op_q;
    logic [31:0]      in1_q, in2_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             capture;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u    = {instr[31:12], 12'h000};
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Shared funct3 -> op map for R-type and I-ALU (alternate forms patched below)
    always_comb begin
        func_op = OpAdd;
        unique case (funct3)
            3'b000: func_op = OpAdd;
            3'b001: func_op = OpSll;
            3'b010: func_op = OpSlt;
            3'b011: func_op = OpSltu;
            3'b100: func_op = OpXor;
            3'b101: func_op = OpSrl;
            3'b110: func_op = OpOr;
            3'b111: func_op = OpAnd;
            default: func_op = OpAdd;
        endcase
    end

    // Instruction decode; anything not matched falls through as an illegal NOP
    always_comb begin
        dec_op      = OpNop;
        dec_in1     = '0;
        dec_in2     = '0;
        dec_illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                7'b0110011: begin
                    if (funct7 == F7Zero ||
                        (funct7 == F7Alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                        dec_illegal = 1'b0;
                        dec_in1     = rs1_data;
                        dec_in2     = is_shift ? {27'b0, rs2_data[4:0]} : rs2_data;
                        dec_op      = func_op;
                        if (funct7 == F7Alt) dec_op = (funct3 == 3'b000) ? OpSub : OpSra;
                    end
                end
                7'b0010011: begin
                    // Shift immediates carry the alternate-form selector in imm[11:5]
                    if (!is_shift || funct7 == F7Zero ||
                        (funct3 == 3'b101 && funct7 == F7Alt)) begin
                        dec_illegal = 1'b0;
                        dec_in1     = rs1_data;
                        dec_in2     = is_shift ? {27'b0, instr[24:20]} : imm_i;
                        dec_op      = (funct3 == 3'b101 && funct7 == F7Alt) ? OpSra : func_op;
                    end
                end
                7'b0110111: begin
                    dec_illegal = 1'b0;
                    dec_op      = OpAdd;
                    dec_in2     = imm_u;
                end
                7'b0010111: begin
                    dec_illegal = 1'b0;
                    dec_op      = OpAdd;
                    dec_in1     = pc;
                    dec_in2     = imm_u;
                end
                7'b0000011: begin
                    dec_illegal = 1'b0;
                    dec_op      = OpAdd;
                    dec_in1     = rs1_data;
                    dec_in2     = imm_i;
                end
                7'b0100011: begin
                    dec_illegal = 1'b0;
                    dec_op      = OpAdd;
                    dec_in1     = rs1_data;
                    dec_in2     = imm_s;
                end
                7'b1100011: begin
                    if (funct3 != 3'b010 && funct3 != 3'b011) begin
                        dec_illegal = 1'b0;
                        dec_in1     = rs1_data;
                        dec_in2     = rs2_data;
                        if (funct3[2:1] == 2'b00)      dec_op = OpSub;
                        else if (funct3[2:1] == 2'b10) dec_op = OpSlt;
                        else                           dec_op = OpSltu;
                    end
                end
                7'b1101111, 7'b1100111: begin
                    if (opcode == 7'b1101111 || funct3 == 3'b000) begin
                        dec_illegal = 1'b0;
                        dec_op      = OpAdd;
                        dec_in1     = pc;
                        dec_in2     = 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Pipeline valid and payload registers; flush wins over any incoming entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            op_q      <= OpNop;
            in1_q     <= '0;
            in2_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (flush)         valid_q <= 1'b0;
            else if (in_ready) valid_q <= in_valid;
            if (capture) begin
                op_q      <= dec_op;
                in1_q     <= dec_in1;
                in2_q     <= dec_in2;
                illegal_q <= dec_illegal;
            end
        end
    end

    // Saturating count of entries handed to execute (flush does not suppress a departure)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q && out_ready && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = valid_q;
    assign alu_op    = op_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign illegal   = illegal_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_alu_issue_stage;

    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic [31:0]   pc = '0;
    logic [31:0]   rs1_data = '0;
    logic [31:0]   rs2_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    alu_op;
    logic [31:0]   alu_in1;
    logic [31:0]   alu_in2;
    logic          illegal;
    logic [CW-1:0] issue_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_valid = 1'b0;
    logic [3:0]  m_op = 4'hF;
    logic [31:0] m_in1 = '0;
    logic [31:0] m_in2 = '0;
    bit          m_ill = 1'b0;
    int          m_cnt = 0;

    alu_issue_stage #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .illegal   (illegal),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    // Returns {illegal, op, in1, in2} for one instruction
    function automatic logic [68:0] ref_decode(input logic [31:0] i, input logic [31:0] p,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [68:0] nop;
        logic [3:0]  arith [8];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] immi, imms, immu, second;
        logic [3:0]  op;
        nop   = {1'b1, 4'hF, 32'h0, 32'h0};
        arith = '{4'h2, 4'hA, 4'hC, 4'hD, 4'h5, 4'h8, 4'h1, 4'h0};
        opc   = i[6:0];
        f3    = i[14:12];
        f7    = i[31:25];
        immi  = 32'($signed(i[31:20]));
        imms  = 32'($signed({i[31:25], i[11:7]}));
        immu  = {i[31:12], 12'h000};
        if (i[1:0] != 2'b11) return nop;
        if (opc == 7'h33) begin
            if (f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) return nop;
            op = arith[f3];
            if (f7 == 7'h20) op = (f3 == 3'd0) ? 4'h6 : 4'h9;
            second = (f3 == 3'd1 || f3 == 3'd5) ? (b & 32'd31) : b;
            return {1'b0, op, a, second};
        end
        if (opc == 7'h13) begin
            op = arith[f3];
            second = immi;
            if (f3 == 3'd1) begin
                if (f7 != 7'h00) return nop;
                second = immi & 32'd31;
            end
            if (f3 == 3'd5) begin
                if (f7 == 7'h20) op = 4'h9;
                else if (f7 != 7'h00) return nop;
                second = immi & 32'd31;
            end
            return {1'b0, op, a, second};
        end
        if (opc == 7'h37) return {1'b0, 4'h2, 32'h0, immu};
        if (opc == 7'h17) return {1'b0, 4'h2, p, immu};
        if (opc == 7'h03) return {1'b0, 4'h2, a, immi};
        if (opc == 7'h23) return {1'b0, 4'h2, a, imms};
        if (opc == 7'h63) begin
            if (f3 == 3'd2 || f3 == 3'd3) return nop;
            op = (f3 < 3'd2) ? 4'h6 : ((f3 < 3'd6) ? 4'hC : 4'hD);
            return {1'b0, op, a, b};
        end
        if (opc == 7'h6F) return {1'b0, 4'h2, p, 32'd4};
        if (opc == 7'h67 && f3 == 3'd0) return {1'b0, 4'h2, p, 32'd4};
        return nop;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        int k;
        int r;
        i = $urandom;
        k = $urandom_range(0, 9);
        r = $urandom_range(0, 3);
        case (k)
            0: i[6:0] = 7'h33;
            1: i[6:0] = 7'h13;
            2: i[6:0] = 7'h37;
            3: i[6:0] = 7'h17;
            4: i[6:0] = 7'h03;
            5: i[6:0] = 7'h23;
            6: i[6:0] = 7'h63;
            7: i[6:0] = 7'h6F;
            8: i[6:0] = 7'h67;
            default: ;
        endcase
        if (r == 0) i[31:25] = 7'h00;
        else if (r == 1) i[31:25] = 7'h20;
        if ($urandom_range(0, 15) == 0) i[1:0] = 2'($urandom_range(0, 2));
        return i;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_op    = 4'hF;
        m_in1   = '0;
        m_in2   = '0;
        m_ill   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock: advance the model from the inputs seen at the edge, return at negedge
    task automatic cycle();
        bit rdy;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = !m_valid || out_ready;
            if (m_valid && out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) m_valid = 1'b0;
            else if (rdy && in_valid) begin
                {m_ill, m_op, m_in1, m_in2} = ref_decode(instr, pc, rs1_data, rs2_data);
                m_valid = 1'b1;
            end else if (rdy) m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, alu_op, alu_in1, alu_in2, illegal, issue_cnt} !==
            {1'b0, 4'hF, 32'h0, 32'h0, 1'b0, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset: got v=%b op=%h in1=%h in2=%h ill=%b cnt=%0d, want 0 f 0 0 0 0",
                     out_valid, alu_op, alu_in1, alu_in2, illegal, issue_cnt);
        end
        rst_n = 1'b1;
        model_reset();
        cycle();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_decode();
        logic [31:0] t_instr [5];
        logic [31:0] t_rs1 [5];
        logic [31:0] t_rs2 [5];
        logic [3:0]  t_op [5];
        logic [31:0] t_in1 [5];
        logic [31:0] t_in2 [5];
        t_instr = '{32'h002081B3, 32'h402081B3, 32'h4030D093, 32'h002091B3, 32'h123452B7};
        t_rs1   = '{32'd5, 32'd9, 32'h80000000, 32'h0000_00F0, 32'h1111_1111};
        t_rs2   = '{32'd7, 32'd4, 32'd0, 32'h00000025, 32'h2222_2222};
        t_op    = '{4'h2, 4'h6, 4'h9, 4'hA, 4'h2};
        t_in1   = '{32'd5, 32'd9, 32'h80000000, 32'h0000_00F0, 32'h0};
        t_in2   = '{32'd7, 32'd4, 32'd3, 32'd5, 32'h12345000};
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            instr    = t_instr[k];
            rs1_data = t_rs1[k];
            rs2_data = t_rs2[k];
            pc       = 32'h0000_1000;
            cycle();
            n_tests++;
            if ({out_valid, alu_op, alu_in1, alu_in2, illegal} !==
                {1'b1, t_op[k], t_in1[k], t_in2[k], 1'b0}) begin
                n_fail++;
                $display("FAIL decode[%0d]: got v=%b op=%h in1=%h in2=%h ill=%b, want 1 %h %h %h 0",
                         k, out_valid, alu_op, alu_in1, alu_in2, illegal,
                         t_op[k], t_in1[k], t_in2[k]);
            end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_hold();
        logic [CW-1:0] cnt0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'h0030F133;
        rs1_data  = 32'hF0F0_1234;
        rs2_data  = 32'h0FF0_00FF;
        cycle();
        cnt0      = CW'(m_cnt);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            instr    = rand_instr();
            rs1_data = $urandom;
            #1;
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_ready[%0d]: got in_ready=%b, want 0", k, in_ready);
            end
            cycle();
            n_tests++;
            if ({out_valid, alu_op, alu_in1, alu_in2, illegal, issue_cnt} !==
                {1'b1, 4'h0, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, cnt0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b op=%h in1=%h in2=%h ill=%b cnt=%0d, want 1 0 f0f01234 0ff000ff 0 %0d",
                         k, out_valid, alu_op, alu_in1, alu_in2, illegal, issue_cnt, cnt0);
            end
        end
        out_ready = 1'b1;
        instr     = 32'h00500093;
        rs1_data  = 32'd100;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got in_ready=%b, want 1", in_ready);
        end
        cycle();
        n_tests++;
        if ({out_valid, alu_op, alu_in1, alu_in2, issue_cnt} !==
            {1'b1, 4'h2, 32'd100, 32'd5, CW'(cnt0 + 1'b1)}) begin
            n_fail++;
            $display("FAIL release: got v=%b op=%h in1=%h in2=%h cnt=%0d, want 1 2 64 5 %0d",
                     out_valid, alu_op, alu_in1, alu_in2, issue_cnt, cnt0 + 1);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_flush();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'hFFFF_FFFF;
        rs1_data  = 32'h1234;
        rs2_data  = 32'h5678;
        cycle();
        n_tests++;
        if ({out_valid, alu_op, alu_in1, alu_in2, illegal} !== {1'b1, 4'hF, 32'h0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal: got v=%b op=%h in1=%h in2=%h ill=%b, want 1 f 0 0 1",
                     out_valid, alu_op, alu_in1, alu_in2, illegal);
        end
        flush = 1'b1;
        instr = 32'h002081B3;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || issue_cnt !== CW'(m_cnt)) begin
            n_fail++;
            $display("FAIL flush: got v=%b cnt=%0d, want 0 %0d", out_valid, issue_cnt, m_cnt);
        end
        cycle();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 32'h00C58633;
        rs1_data  = 32'd3;
        rs2_data  = 32'd4;
        cycle();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({out_valid, alu_op, alu_in1, alu_in2, illegal, issue_cnt} !==
            {1'b0, 4'hF, 32'h0, 32'h0, 1'b0, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b op=%h in1=%h in2=%h ill=%b cnt=%0d, want 0 f 0 0 0 0",
                     out_valid, alu_op, alu_in1, alu_in2, illegal, issue_cnt);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();
        n_tests++;
        if (out_valid !== 1'b0 || issue_cnt !== '0) begin
            n_fail++;
            $display("FAIL post_reset: got v=%b cnt=%0d, want 0 0", out_valid, issue_cnt);
        end
    endtask

    task automatic test_saturation();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < CNT_MAX + 6; k++) begin
            instr    = rand_instr();
            rs1_data = $urandom;
            rs2_data = $urandom;
            cycle();
        end
        n_tests++;
        if (issue_cnt !== CW'(CNT_MAX) || m_cnt != CNT_MAX) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d, want %0d", issue_cnt, CNT_MAX);
        end
        in_valid = 1'b0;
        cycle();
        n_tests++;
        if (issue_cnt !== CW'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL saturate_hold: got cnt=%0d, want %0d", issue_cnt, CNT_MAX);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            instr     = rand_instr();
            pc        = $urandom;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            #1;
            n_tests++;
            if (in_ready !== (!m_valid || out_ready)) begin
                n_fail++;
                bad++;
                if (bad < 10) $display("FAIL rand_ready[%0d]: got %b, want %b", k, in_ready,
                                       !m_valid || out_ready);
            end
            cycle();
            n_tests++;
            if (out_valid !== m_valid || issue_cnt !== CW'(m_cnt) ||
                (m_valid && {alu_op, alu_in1, alu_in2, illegal} !== {m_op, m_in1, m_in2, m_ill}))
            begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand[%0d]: got v=%b op=%h in1=%h in2=%h ill=%b cnt=%0d, want v=%b op=%h in1=%h in2=%h ill=%b cnt=%0d",
                             k, out_valid, alu_op, alu_in1, alu_in2, illegal, issue_cnt,
                             m_valid, m_op, m_in1, m_in2, m_ill, m_cnt);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_hold();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the 4-bit ALU operation code and both ALU operands from an RV32I instruction word.
- Registers the result into a valid/ready pipeline register that feeds the execute stage.
- Sits between register-file read and the ALU; it is the sole producer of the ALU operation encoding.

Parameters:
CNT_W, 16, width of the saturating issued-instruction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush, discards held and incoming entry
in_valid  input  1  instruction/operands valid
in_ready  output  1  stage can accept this cycle
instr  input  32  instruction word
pc  input  32  instruction address
rs1_data  input  32  register-file read data for rs1
rs2_data  input  32  register-file read data for rs2
out_valid  output  1  registered entry valid
out_ready  input  1  execute stage accepts entry
alu_op  output  4  ALU operation code
alu_in1  output  32  ALU operand 1
alu_in2  output  32  ALU operand 2
illegal  output  1  entry is not a decodable RV32I ALU-using instruction
issue_cnt  output  CNT_W  count of entries accepted by execute, saturating

Behaviour:
- Reset (async, rst_n=0): out_valid=0, alu_op=4'b1111, alu_in1=0, alu_in2=0, illegal=0, issue_cnt=0. Reset mid-transfer drops the held entry. No entry appears until an in_valid handshake after rst_n deasserts.
- in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
- Capture when in_valid && in_ready && !flush. Outputs are valid the next cycle (latency 1). Full throughput: back-to-back accept when out_ready=1.
- Hold while out_valid && !out_ready. All outputs are stable and no capture occurs.
- Flush takes priority. Next cycle out_valid=0, and any same-cycle input is dropped. A flush with out_valid && out_ready counts the departing entry.
- issue_cnt increments on out_valid && out_ready and saturates at all-ones.
- Op codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SRL 1000, SRA 1001, XOR 0101, SLT 1100, SLTU 1101, SLL 1010, NOP 1111.
- R-type (opcode 0110011):
  - in1=rs1_data, in2=rs2_data.
  - funct3 maps 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - funct7 0100000 is legal only with 000 (SUB) and 101 (SRA). Any funct7 other than 0000000 or 0100000 is illegal.
- I-ALU (0010011):
  - in1=rs1_data, in2=sign-extended imm[11:0].
  - Same funct3 map; funct3 000 is always ADD (no SUBI).
  - SLLI requires imm[11:5]=0. SRLI/SRAI require imm[11:5] of 0000000 or 0100000 respectively; otherwise illegal.
- Shift amount: for every shift op, in2 = {27'b0, amount[4:0]}. This applies to both R-type and I-type.
- LUI (0110111): in1=0, in2={instr[31:12],12'b0}, ADD.
- AUIPC (0010111): in1=pc, in2=U-imm, ADD.
- Loads (0000011): in1=rs1_data, in2=I-imm, ADD.
- Stores (0100011): in1=rs1_data, in2=S-imm, ADD.
- Branches (1100011): in1=rs1_data, in2=rs2_data.
  - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - funct3 010 and 011 are illegal.
- JAL (1101111) and JALR (1100111, funct3 000 only): in1=pc, in2=32'd4, ADD.
- Any other encoding: alu_op=1111, alu_in1=0, alu_in2=0, illegal=1, still issued as a normal entry.
- instr[1:0] != 2'b11 is illegal.

Test Plan:
- Reset, then in_valid with instr=0x002081B3 (ADD), rs1=5, rs2=7 → next cycle out_valid=1, alu_op=0010, in1=5, in2=7, illegal=0.
- instr=0x402081B3 (SUB) → alu_op=0110. Then instr=0x4030D093 (SRAI x1,x1,3), rs1=0x80000000 → alu_op=1001, in2=3.
- R-type SLL with rs2_data=0x00000025 → alu_op=1010, in2=5. instr=0x123452B7 (LUI) → in1=0, in2=0x12345000, alu_op=0010.
- out_ready=0 for 3 cycles after a capture: in_ready=0, outputs unchanged, issue_cnt unchanged. out_ready=1 → issue_cnt +1, next entry accepted the same cycle.
- instr=0xFFFFFFFF → alu_op=1111, illegal=1. Then assert flush together with in_valid → out_valid=0 next cycle, input dropped.
- rst_n pulsed low asynchronously while out_valid=1 and out_ready=0 → out_valid=0 and issue_cnt=0 immediately. Force issue_cnt to all-ones via back-to-back issues (CNT_W=4 build): count stays 4'hF.
